// File: rtl/memory_stage_pkg.sv
// Shared types and helpers for the memory stage.
// Size constants follow the load/store funct3 encoding.
package memory_stage_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_t;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  localparam logic [2:0] MEM_SIZE_B  = 3'b000;
  localparam logic [2:0] MEM_SIZE_H  = 3'b001;
  localparam logic [2:0] MEM_SIZE_W  = 3'b010;
  localparam logic [2:0] MEM_SIZE_BU = 3'b100;
  localparam logic [2:0] MEM_SIZE_HU = 3'b101;

  function automatic logic [3:0] store_strb(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    unique case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic data_t store_data(
    input logic [1:0] sz,
    input data_t      wd
  );
    unique case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_to_wb_if.sv
// Memory-to-write-back bundle.
// The memory stage drives it through to_write_back.
interface mem_to_wb_if;
  import memory_stage_pkg::*;

  result_src_t cfsm__result_src;
  data_t       read_data;
  data_t       alu_result;
  logic [4:0]  rd;

  modport to_write_back (
    output cfsm__result_src, read_data, alu_result, rd
  );

  modport from_memory (
    input cfsm__result_src, read_data, alu_result, rd
  );
endinterface

// File: rtl/memory_stage_load_extend.sv
// Load lane select with sign/zero extension.
// Misaligned halves fall back to the aligned lane.
module load_extend
  import memory_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr,
  input  data_t      rdata,
  output data_t      ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      MEM_SIZE_B:  ext = {{24{b[7]}}, b};
      MEM_SIZE_H:  ext = {{16{h[15]}}, h};
      MEM_SIZE_BU: ext = {24'b0, b};
      MEM_SIZE_HU: ext = {16'b0, h};
      default:     ext = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: one bus access in flight, stalls execute meanwhile.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  mem_op_t     ex_mem_op,
  input  logic [2:0]  ex_funct3,
  input  data_t       ex_alu_result,
  input  data_t       ex_write_data,
  input  logic [4:0]  ex_rd,
  input  result_src_t ex_result_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  mem_to_wb_if.to_write_back wb,
  output logic        wb_valid,
  output logic        mem_fault
);

  localparam logic [31:0] CNT_MAX = 32'(MAX_WAIT - 1);

  mem_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  data_t       i_alu_q, i_alu_d;
  logic [4:0]  i_rd_q, i_rd_d;
  result_src_t i_src_q, i_src_d;
  data_t       wb_alu_q, wb_alu_d;
  data_t       wb_rdata_q, wb_rdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  result_src_t wb_src_q, wb_src_d;
  logic        wb_valid_q, wb_valid_d;
  logic        fault_q, fault_d;
  logic        misalign;
  logic        is_store;
  data_t       ld_ext;

  load_extend u_load_extend (
    .funct3 (f3_q),
    .addr   (alo_q),
    .rdata  (mem_rdata),
    .ext    (ld_ext)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (ex_mem_op != MEM_OP_NONE) &&
    (((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
     ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign is_store = (ex_mem_op == MEM_OP_STORE);
  assign ex_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    f3_d       = f3_q;
    alo_d      = alo_q;
    i_alu_d    = i_alu_q;
    i_rd_d     = i_rd_q;
    i_src_d    = i_src_q;
    wb_alu_d   = wb_alu_q;
    wb_rdata_d = wb_rdata_q;
    wb_rd_d    = wb_rd_q;
    wb_src_d   = wb_src_q;
    wb_valid_d = 1'b0;
    fault_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          f3_d    = ex_funct3;
          alo_d   = ex_alu_result[1:0];
          i_alu_d = ex_alu_result;
          i_rd_d  = ex_rd;
          i_src_d = ex_result_src;
          if (ex_mem_op == MEM_OP_NONE || misalign) begin
            wb_alu_d   = ex_alu_result;
            wb_rd_d    = misalign ? 5'd0 : ex_rd;
            wb_src_d   = ex_result_src;
            wb_rdata_d = '0;
            wb_valid_d = 1'b1;
            fault_d    = misalign;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {ex_alu_result[31:2], 2'b00};
            wdata_d = is_store ?
              store_data(ex_funct3[1:0], ex_write_data) : '0;
            wstrb_d = is_store ?
              store_strb(ex_funct3[1:0], ex_alu_result[1:0]) : 4'b0;
          end
        end
      end
      default: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          wb_alu_d   = i_alu_q;
          wb_rd_d    = i_rd_q;
          wb_src_d   = i_src_q;
          wb_rdata_d = we_q ? '0 : ld_ext;
          wb_valid_d = 1'b1;
        end else if (MAX_WAIT != 0 && cnt_q == CNT_MAX) begin
          // abandoned access: no register write
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          wb_alu_d   = i_alu_q;
          wb_rd_d    = 5'd0;
          wb_src_d   = i_src_q;
          wb_rdata_d = '0;
          wb_valid_d = 1'b1;
          fault_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      f3_q       <= '0;
      alo_q      <= '0;
      i_alu_q    <= '0;
      i_rd_q     <= '0;
      i_src_q    <= result_src_t'(2'd0);
      wb_alu_q   <= '0;
      wb_rdata_q <= '0;
      wb_rd_q    <= '0;
      wb_src_q   <= result_src_t'(2'd0);
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      f3_q       <= f3_d;
      alo_q      <= alo_d;
      i_alu_q    <= i_alu_d;
      i_rd_q     <= i_rd_d;
      i_src_q    <= i_src_d;
      wb_alu_q   <= wb_alu_d;
      wb_rdata_q <= wb_rdata_d;
      wb_rd_q    <= wb_rd_d;
      wb_src_q   <= wb_src_d;
      wb_valid_q <= wb_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign wb_valid  = wb_valid_q;
  assign mem_fault = fault_q;

  assign wb.alu_result       = wb_alu_q;
  assign wb.read_data        = wb_rdata_q;
  assign wb.rd               = wb_rd_q;
  assign wb.cfsm__result_src = wb_src_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a behavioural model.
// Honours MEM_MISALIGN_TRAP_EN if it is defined for the build.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  mem_op_t     ex_mem_op = MEM_OP_NONE;
  logic [2:0]  ex_funct3 = '0;
  data_t       ex_alu_result = '0;
  data_t       ex_write_data = '0;
  logic [4:0]  ex_rd = '0;
  result_src_t ex_result_src = RES_ALU;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic        mem_fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_to_wb_if wbi ();

  memory_stage #(.MAX_WAIT(MW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_mem_op     (ex_mem_op),
    .ex_funct3     (ex_funct3),
    .ex_alu_result (ex_alu_result),
    .ex_write_data (ex_write_data),
    .ex_rd         (ex_rd),
    .ex_result_src (ex_result_src),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .wb            (wbi.to_write_back),
    .wb_valid      (wb_valid),
    .mem_fault     (mem_fault)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    int sh;
    sh = 8 * int'(a[1:0]);
    case (f3)
      3'd0: begin
        v = (w >> sh) & 32'hFF;
        if (v >= 32'd128) v = v | 32'hFFFF_FF00;
      end
      3'd4: v = (w >> sh) & 32'hFF;
      3'd1: begin
        v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        if (v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      3'd5: v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_strb(input logic [2:0] f3,
                                           input logic [31:0] a);
    int s;
    case (f3)
      3'd0:    s = 1 << int'(a[1:0]);
      3'd1:    s = 3 << (2 * int'(a[1]));
      default: s = 15;
    endcase
    return 32'(s);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3,
                                            input logic [31:0] w);
    case (f3)
      3'd0:    return (w & 32'hFF) * 32'h0101_0101;
      3'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_trap(input mem_op_t op, input logic [2:0] f3,
                                  input logic [31:0] a);
    bit en;
    en = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    en = 1'b1;
`endif
    if (!en || op == MEM_OP_NONE) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return a % 2 != 0;
    if (f3 == 3'd2) return a % 4 != 0;
    return 1'b0;
  endfunction

  task automatic do_op(input mem_op_t op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input logic [4:0] rd,
                       input result_src_t src, input int k);
    bit tr;
    bit to;
    bit st;
    int waits;
    tr = ref_trap(op, f3, a);
    to = (k >= MW);
    st = (op == MEM_OP_STORE);
    @(negedge clk);
    check("ex_ready_idle", ex_ready, 1);
    ex_valid = 1'b1;
    ex_mem_op = op;
    ex_funct3 = f3;
    ex_alu_result = a;
    ex_write_data = wd;
    ex_rd = rd;
    ex_result_src = src;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    if (op == MEM_OP_NONE || tr) begin
      check("wb_valid_fast", wb_valid, 1);
      check("fault_fast", mem_fault, tr);
      check("rd_fast", wbi.rd, tr ? 5'd0 : rd);
      check("read_data_fast", wbi.read_data, 0);
      check("ready_fast", ex_ready, 1);
      check("no_req_fast", mem_req, 0);
    end else begin
      check("req_start", mem_req, 1);
      check("we", mem_we, st);
      check("addr", mem_addr, a & 32'hFFFF_FFFC);
      check("ready_busy", ex_ready, 0);
      if (st) begin
        check("wstrb", mem_wstrb, ref_strb(f3, a));
        check("wdata", mem_wdata, ref_wdata(f3, wd));
      end
      // a second instruction waits while the access is pending
      ex_valid = 1'b1;
      ex_mem_op = MEM_OP_NONE;
      ex_rd = rd ^ 5'd1;
      ex_alu_result = ~a;
      waits = to ? MW - 1 : k;
      for (int i = 0; i < waits; i++) begin
        @(posedge clk);
        #1;
        check("req_held", mem_req, 1);
        check("we_held", mem_we, st);
        check("ready_stall", ex_ready, 0);
        check("no_wb_busy", wb_valid, 0);
      end
      if (!to) begin
        mem_ack = 1'b1;
        mem_rdata = rdat;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      ex_valid = 1'b0;
      check("wb_valid_done", wb_valid, 1);
      check("fault_done", mem_fault, to);
      check("req_drop", mem_req, 0);
      check("ready_done", ex_ready, 1);
      check("rd_done", wbi.rd, to ? 5'd0 : rd);
      check("read_data", wbi.read_data,
            (to || st) ? 32'd0 : ref_load(f3, a, rdat));
    end
    check("alu_result", wbi.alu_result, a);
    check("result_src", wbi.cfsm__result_src, src);
    mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("wb_pulse_end", wb_valid, 0);
    check("fault_pulse_end", mem_fault, 0);
    check("idle_no_req", mem_req, 0);
    check("alu_hold", wbi.alu_result, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_op_t op;
    logic [2:0] f3;
    logic [2:0] lf3 [5];
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2;
    lf3[3] = 3'd4; lf3[4] = 3'd5;

    #12;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_read_data", wbi.read_data, 0);
    check("rst_alu", wbi.alu_result, 0);
    check("rst_rd", wbi.rd, 0);
    check("rst_src", wbi.cfsm__result_src, 0);
    check("rst_ready", ex_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    do_op(MEM_OP_NONE, 3'd0, 32'h1234, 32'h0, 32'h0, 5'd5, RES_ALU, 0);
    do_op(MEM_OP_LOAD, 3'd0, 32'h1003, 32'h0, 32'h80FF_FF00, 5'd7,
          RES_MEM, 3);
    do_op(MEM_OP_STORE, 3'd1, 32'h2002, 32'hABCD_1234, 32'h0, 5'd0,
          RES_ALU, 2);
    do_op(MEM_OP_LOAD, 3'd5, 32'h10, 32'h0, 32'h0000_F00F, 5'd9,
          RES_MEM, 0);
    do_op(MEM_OP_LOAD, 3'd2, 32'h100, 32'h0, 32'h1111_2222, 5'd11,
          RES_MEM, MW);
    do_op(MEM_OP_LOAD, 3'd2, 32'h1001, 32'h0, 32'hDEAD_BEEF, 5'd12,
          RES_MEM, 1);
    do_op(MEM_OP_STORE, 3'd0, 32'h3001, 32'h0000_00A5, 32'h0, 5'd1,
          RES_PC4, MW + 1);

    for (int n = 0; n < 80; n++) begin
      op = mem_op_t'($urandom_range(0, 2));
      if (op == MEM_OP_STORE) f3 = lf3[$urandom_range(0, 2)];
      else f3 = lf3[$urandom_range(0, 4)];
      do_op(op, f3, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)),
            result_src_t'($urandom_range(0, 2)),
            $urandom_range(0, MW + 1));
    end

    // reset during an access withdraws the request at once
    @(negedge clk);
    ex_valid = 1'b1;
    ex_mem_op = MEM_OP_LOAD;
    ex_funct3 = 3'd2;
    ex_alu_result = 32'h4000;
    ex_rd = 5'd3;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    check("rst_mid_req_before", mem_req, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_ready", ex_ready, 1);
    check("rst_mid_wb", wb_valid, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_5555;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("rst_ack_lost", wb_valid, 0);
    check("rst_after_req", mem_req, 0);
    do_op(MEM_OP_NONE, 3'd0, 32'h55AA, 32'h0, 32'h0, 5'd30, RES_PC4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipelined memory-access stage: takes one instruction per handshake from execute, performs any load/store on a single-outstanding request/acknowledge data bus, aligns and sign-extends load data, and drives the `to_write_back` side of the memory-to-write-back interface. Sits between the execute stage and the write-back stage. Stalls execute while a bus access is pending.

## Interface

Parameters:
- `MAX_WAIT`, default 255: cycles to wait for `mem_ack` before abandoning an access; 0 disables the timeout.

Ports:
- `clk`  in  1  stage clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute presents an instruction.
- `ex_ready`  out  1  stage can accept; high only in IDLE.
- `ex_mem_op`  in  `mem_op_t`  NONE / LOAD / STORE.
- `ex_funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ex_alu_result`  in  `data_t`  ALU result; byte address for memory ops.
- `ex_write_data`  in  `data_t`  store data (rs2).
- `ex_rd`  in  5  destination register.
- `ex_result_src`  in  `result_src_t`  passed through to write-back.
- `mem_req`  out  1  bus request, held until acknowledged.
- `mem_we`  out  1  store when high.
- `mem_addr`  out  32  word address; bits [1:0] always 0.
- `mem_wdata`  out  32  store data replicated into byte lanes.
- `mem_wstrb`  out  4  byte-enable for stores.
- `mem_ack`  in  1  one-cycle completion pulse.
- `mem_rdata`  in  32  read word; valid only with `mem_ack`.
- `wb`  modport `mem_to_wb_if.to_write_back`: `cfsm__result_src`, `read_data`, `alu_result`, `rd`.
- `wb_valid`  out  1  one-cycle pulse: `wb` fields carry a completed instruction.
- `mem_fault`  out  1  one-cycle pulse with `wb_valid` for a timed-out (or trapped, see Configuration) access.

## Operation

- States: IDLE, ACCESS.
- IDLE, `ex_valid && ex_ready`: latch all `ex_*` fields. NONE: drive `wb` next cycle, stay IDLE. LOAD/STORE: go to ACCESS, assert `mem_req` from the next cycle.
- ACCESS: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` held stable. On `mem_ack`: capture `mem_rdata`, go to IDLE, pulse `wb_valid` next cycle.
- Store strobes: B → `4'b0001 << addr[1:0]`; H → `4'b0011 << {addr[1],1'b0}`; W → `4'b1111`. Data: byte replicated ×4, half ×2.
- Load extract: select lane by `addr[1:0]`; B/H sign-extend; BU/HU zero-extend; W as-is. Stores and NONE drive `read_data` = 0.
- `alu_result`, `rd`, `cfsm__result_src` always pass through from the latched instruction.
- Timeout: counter clears on entry to ACCESS and increments each cycle without ack; at `MAX_WAIT`, drop `mem_req`, return to IDLE, pulse `wb_valid` and `mem_fault`, force `rd` = 0.
- `mem_ack` in IDLE is ignored.

## Timing

- Reset values: state IDLE; `mem_req`, `mem_we`, `wb_valid`, `mem_fault` = 0; `mem_addr`, `mem_wdata`, `mem_wstrb`, `read_data`, `alu_result`, `rd` = 0; `cfsm__result_src` = enum zero encoding; timeout counter = 0.
- NONE: accept at cycle N, `wb_valid` at N+1. `ex_ready` stays high, so throughput is 1/cycle.
- Memory op: accept at N, `mem_req` from N+1, ack at N+1+k (k ≥ 0), `wb_valid` at N+2+k. `ex_ready` low from N+1 through the ack cycle, high the cycle after.
- Reset mid-access: `mem_req` drops immediately (asynchronous), and a pending ack is lost. The bus must tolerate request withdrawal on reset only.
- `wb` fields hold their value between pulses.

## Configuration

- `MEM_MISALIGN_TRAP_EN` defined: H with `addr[0]`≠0, or W with `addr[1:0]`≠0, issues no bus request. The instruction completes as if IDLE/NONE (`wb_valid` at N+1) with `mem_fault` = 1 and `rd` = 0.
- Undefined: misaligned addresses use only the aligned lane selection above. Offending low address bits are ignored and there is no fault.

## Structure

- Shared package: `mem_op_t`, funct3 size constants (`MEM_SIZE_B`, `MEM_SIZE_H`, `MEM_SIZE_W`, `MEM_SIZE_BU`, `MEM_SIZE_HU`), alongside the existing `data_t` and `result_src_t`.
- One sub-module, `load_extend`: combinational lane select plus sign/zero extension (inputs `funct3`, `addr[1:0]`, `rdata`).

## Test plan

- NONE op, `alu_result`=0x1234, `rd`=5 → `wb_valid` next cycle, `alu_result`=0x1234, `rd`=5, `read_data`=0, `ex_ready` never low.
- LB at 0x1003, `mem_rdata`=0x80FF_FF00, ack after 3 cycles → `mem_addr`=0x1000, `read_data`=0xFFFF_FF80, `wb_valid` exactly one cycle after ack.
- SH at 0x2002, data 0xABCD_1234 → `mem_wstrb`=0b1100, `mem_wdata`=0x1234_1234, `mem_we`=1 held until ack.
- LHU at 0x10, `mem_rdata`=0x0000_F00F → `read_data`=0x0000_F00F. Back-to-back `ex_valid` → second accepted only after first `wb_valid`.
- `MAX_WAIT`=4, no ack → `mem_req` drops after 4 cycles, `mem_fault` and `wb_valid` pulse, `rd`=0.
- With `MEM_MISALIGN_TRAP_EN`: LW at 0x1001 → no `mem_req`, `mem_fault`=1 at N+1. Without it: `mem_addr`=0x1000, normal completion.
